// File: rtl/system_sysid_ext_if.sv
// Avalon-MM control-slave bundle for the system ID block.
`timescale 1ns/1ps
interface system_sysid_ext_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/system_sysid_ext.sv
// System ID peripheral: constants, 64-bit uptime with hi snapshot,
// seconds counter with tick, scratch and control registers.
`timescale 1ns/1ps
module system_sysid_ext #(
    parameter logic [31:0] SYS_ID         = 32'h5335_24AF,
    parameter logic [31:0] TIMESTAMP      = 32'd0,
    parameter logic [31:0] BUILD_VER      = 32'h0001_0000,
    parameter int          CLK_FREQ_HZ    = 50000000,
    parameter int          ADDR_W         = 3,
    parameter logic [63:0] UPTIME_PRELOAD = 64'd0
) (
    input  logic                clock,
    input  logic                reset,
    system_sysid_ext_if.slave   bus,
    output logic                tick
);

    localparam int            PW    = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0] P_TOP = PW'(CLK_FREQ_HZ - 1);

    logic [63:0]   uptime;
    logic [31:0]   uptime_hi_shadow;
    logic [31:0]   seconds;
    logic [31:0]   scratch;
    logic [PW-1:0] prescaler;
    logic          tick_en;

    logic [2:0]    word;
    logic          in_map;
    logic          ctl_wr;
    logic          scr_wr;
    logic          lo_rd;
    logic          clr;
    logic          terminal;
    logic [31:0]   rd_word;
    logic [31:0]   scratch_nxt;

    assign word     = bus.address[2:0];
    assign in_map   = ((bus.address >> 3) == '0);
    assign ctl_wr   = bus.write && in_map && (word == 3'd7)
                      && bus.byteenable[0];
    assign scr_wr   = bus.write && in_map && (word == 3'd6);
    assign lo_rd    = bus.read && in_map && (word == 3'd3);
    assign clr      = ctl_wr && bus.writedata[0];
    assign terminal = (prescaler == P_TOP);

    // Read mux sees pre-write state, so same-cycle RW returns old data.
    always_comb begin
        rd_word = 32'd0;
        if (in_map) begin
            unique case (word)
                3'd0: rd_word = SYS_ID;
                3'd1: rd_word = TIMESTAMP;
                3'd2: rd_word = BUILD_VER;
                3'd3: rd_word = uptime[31:0];
                3'd4: rd_word = uptime_hi_shadow;
                3'd5: rd_word = seconds;
                3'd6: rd_word = scratch;
                3'd7: rd_word = {30'd0, tick_en, 1'b0};
            endcase
        end
    end

    always_comb begin
        scratch_nxt = scratch;
        for (int i = 0; i < 4; i++) begin
            if (bus.byteenable[i]) begin
                scratch_nxt[8*i +: 8] = bus.writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.readdata      <= 32'd0;
            bus.readdatavalid <= 1'b0;
            tick              <= 1'b0;
            uptime            <= UPTIME_PRELOAD;
            uptime_hi_shadow  <= 32'd0;
            seconds           <= 32'd0;
            prescaler         <= '0;
            scratch           <= 32'd0;
            tick_en           <= 1'b1;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                bus.readdata <= rd_word;
            end
            if (lo_rd) begin
                uptime_hi_shadow <= uptime[63:32];
            end
            // Clear wins over a coincident terminal count.
            if (clr) begin
                uptime    <= 64'd0;
                seconds   <= 32'd0;
                prescaler <= '0;
                tick      <= 1'b0;
            end else begin
                uptime <= uptime + 64'd1;
                if (terminal) begin
                    prescaler <= '0;
                    seconds   <= seconds + 32'd1;
                    tick      <= tick_en;
                end else begin
                    prescaler <= prescaler + 1'b1;
                    tick      <= 1'b0;
                end
            end
            if (ctl_wr) begin
                tick_en <= bus.writedata[1];
            end
            if (scr_wr) begin
                scratch <= scratch_nxt;
            end
        end
    end

endmodule
